// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  div_sequencer : restoring shift-subtract divider controller for RV32M
//                  DIV/DIVU/REM/REMU. Optional macro DIV_EARLY_OUT_EN enables
//                  a one-cycle shortcut when |dividend| < |divisor|.
//  Revision 1.0
// ============================================================================
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_division,
   output logic             overflow_signed_div
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             dvd_neg_q, dvd_neg_d;
   logic             dvs_neg_q, dvs_neg_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zdiv_q, zdiv_d;
   logic             ovf_q, ovf_d;

   logic             w_signed, w_dvd_neg, w_dvs_neg, w_accept, w_ge;
   logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs, w_quo_fix, w_rem_fix;
   logic [WIDTH:0]   w_rem_sh, w_trial;
   logic             w_unused;

   assign w_signed  = ~op[0];
   assign w_dvd_neg = w_signed & dividend[WIDTH-1];
   assign w_dvs_neg = w_signed & divisor[WIDTH-1];
   assign w_abs_dvd = w_dvd_neg ? -dividend : dividend;
   assign w_abs_dvs = w_dvs_neg ? -divisor  : divisor;
   assign w_accept  = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

   // Remainder is kept one bit wider during the trial so unsigned divisors
   // above 2^(WIDTH-1) do not lose the shifted-out MSB.
   assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign w_trial  = w_rem_sh - {1'b0, dvs_q};
   assign w_ge     = (w_rem_sh >= {1'b0, dvs_q});
   assign w_unused = w_trial[WIDTH];

   assign w_quo_fix = (~op_q[0] & (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
   assign w_rem_fix = (~op_q[0] & dvd_neg_q) ? -rem_q : rem_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zdiv_d    = zdiv_q;
      ovf_d     = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (w_accept) begin
               op_d      = op;
               dvd_neg_d = w_dvd_neg;
               dvs_neg_d = w_dvs_neg;
               if (divisor == '0) begin
                  state_d  = S_DONE;
                  result_d = op[1] ? dividend : ALL_ONES;
                  zdiv_d   = 1'b1;
                  ovf_d    = 1'b0;
               end else if (w_signed && dividend == MIN_VAL && divisor == ALL_ONES) begin
                  state_d  = S_DONE;
                  result_d = op[1] ? '0 : MIN_VAL;
                  zdiv_d   = 1'b0;
                  ovf_d    = 1'b1;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (w_abs_dvd < w_abs_dvs) begin
                  state_d  = S_DONE;
                  result_d = op[1] ? dividend : '0;
                  zdiv_d   = 1'b0;
                  ovf_d    = 1'b0;
               end
`endif
               else begin
                  state_d = S_CALC;
                  quo_d   = w_abs_dvd;
                  dvs_d   = w_abs_dvs;
                  rem_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         S_CALC: begin
            quo_d = {quo_q[WIDTH-2:0], w_ge};
            rem_d = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = op_q[1] ? w_rem_fix : w_quo_fix;
            zdiv_d   = 1'b0;
            ovf_d    = 1'b0;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zdiv_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zdiv_q    <= zdiv_d;
         ovf_q     <= ovf_d;
      end
   end

   assign stall               = (state_q == S_CALC) | (state_q == S_FIX);
   assign done                = (state_q == S_DONE);
   assign result              = result_q;
   assign zero_division       = zdiv_q;
   assign overflow_signed_div = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_div_sequencer : directed self-checking bench for div_sequencer.
//  Revision 1.0
// ============================================================================
module tb_div_sequencer;

   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = W + 2;
`endif

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    op = 2'd0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          stall, done, zero_division, overflow_signed_div;
   logic [W-1:0]  result;

   int n_checks = 0;
   int n_pass   = 0;

   div_sequencer #(.WIDTH(W)) dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .start               (start),
      .op                  (op),
      .dividend            (dividend),
      .divisor             (divisor),
      .flush               (flush),
      .stall               (stall),
      .done                (done),
      .result              (result),
      .zero_division       (zero_division),
      .overflow_signed_div (overflow_signed_div)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Waits (bounded) for done; n counts edges since the accept edge.
   task automatic wait_done(inout int n, inout int st);
      while (!done && n < 200) begin
         if (stall) st++;
         @(posedge CLK); #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_zd, input logic exp_ov, input int exp_lat);
      int n;
      int st;
      op = o; dividend = a; divisor = b; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      n = 1; st = 0;
      chk({tag, "_done_at_accept"}, 32'(done), 32'(exp_lat == 1));
      wait_done(n, st);
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_stall_cycles"}, 32'(st), (exp_lat == 1) ? 32'd0 : 32'(W + 1));
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_zero_div"}, 32'(zero_division), 32'(exp_zd));
      chk({tag, "_overflow"}, 32'(overflow_signed_div), 32'(exp_ov));
      chk({tag, "_stall_in_done"}, 32'(stall), 32'd0);
   endtask

   initial begin
      int n;
      int st;
      int seen;

      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, zero_division, overflow_signed_div}, 32'd0);
      #13 RESET = 1'b1;
      @(posedge CLK); #1;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W + 2);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, W + 2);
      repeat (2) @(posedge CLK); #1;
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, W + 2);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 2);
      run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, W + 2);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, W + 2);
      run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 1'b0, W + 2);
      run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 1'b0, W + 2);
      run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 1);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1);
      @(posedge CLK); #1;
      chk("done_one_cycle", 32'(done), 32'd0);

      // A start arriving mid-calculation must be ignored.
      op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; n = 1; st = 0;
      repeat (3) begin @(posedge CLK); #1; n++; end
      op = 2'b01; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; n++;
      wait_done(n, st);
      chk("ignore_start_latency", 32'(n), 32'(W + 2));
      chk("ignore_start_result", result, 32'd14);

      run_op("b2b_divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, W + 2);
      run_op("divu_3_9", 2'b01, 32'd3, 32'd9, 32'd0, 1'b0, 1'b0, EO_LAT);
      run_op("rem_m3_9", 2'b10, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD, 1'b0, 1'b0, EO_LAT);
      repeat (2) @(posedge CLK); #1;

      // Flush ten cycles into an operation.
      op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (9) @(posedge CLK); #1;
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_done", 32'(done), 32'd0);
      chk("flush_result_kept", result, 32'hFFFF_FFFD);
      seen = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (done || stall) seen++;
      end
      chk("flush_no_done", 32'(seen), 32'd0);

      // Flush and start together: nothing accepted.
      op = 2'b01; dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_stall", 32'(stall), 32'd0);
      chk("flush_start_done", 32'(done), 32'd0);
      chk("flush_start_result", result, 32'hFFFF_FFFD);

      // Asynchronous reset in the middle of CALC.
      op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (5) @(posedge CLK); #1;
      chk("pre_reset_stall", 32'(stall), 32'd1);
      RESET = 1'b0;
      #1;
      chk("areset_stall", 32'(stall), 32'd0);
      chk("areset_done", 32'(done), 32'd0);
      chk("areset_result", result, 32'd0);
      chk("areset_flags", {30'd0, zero_division, overflow_signed_div}, 32'd0);
      #3 RESET = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (done || stall) seen++;
      end
      chk("post_reset_idle", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
